mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the core's single memory bus port between two requesters: instruction fetch (IF) and load/store (LS, the MEM stage).
- The control FSM raises IF and LS requests. This block arbitrates between them, runs one bus transaction at a time with a valid/ack handshake, and returns read data plus a one-cycle done pulse to the winner.
- A wait-state watchdog aborts stalled transactions so the control FSM can never hang.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the bus.
- DATA_WIDTH, 32, data width. Byte-enable width is DATA_WIDTH/8.
- TIMEOUT, 16, maximum clock edges a bus request may wait for ack. 0 disables the watchdog.

Ports:
- mem_arbiter_clock_in  in  1  clock; all logic on posedge.
- mem_arbiter_reset_in  in  1  asynchronous, active-low reset.
- if_req_in  in  1  fetch request; held until if_gnt_out.
- if_addr_in  in  ADDR_WIDTH  fetch address.
- if_gnt_out  out  1  one-cycle pulse: fetch request accepted.
- if_done_out  out  1  one-cycle pulse: fetch finished.
- if_rdata_out  out  DATA_WIDTH  fetched word; held until the next IF done.
- ls_req_in  in  1  load/store request; held until ls_gnt_out.
- ls_we_in  in  1  1 = store, 0 = load.
- ls_addr_in  in  ADDR_WIDTH  load/store address.
- ls_wdata_in  in  DATA_WIDTH  store data.
- ls_be_in  in  DATA_WIDTH/8  store byte enables.
- ls_gnt_out  out  1  one-cycle pulse: LS request accepted.
- ls_done_out  out  1  one-cycle pulse: LS finished.
- ls_rdata_out  out  DATA_WIDTH  load data; held until the next LS load done.
- err_out  out  1  high together with a done pulse when that transaction timed out.
- bus_req_out  out  1  bus request valid.
- bus_we_out  out  1  bus write enable.
- bus_addr_out  out  ADDR_WIDTH  bus address.
- bus_wdata_out  out  DATA_WIDTH  bus write data.
- bus_be_out  out  DATA_WIDTH/8  bus byte enables.
- bus_ack_in  in  1  bus completion. Read data is valid in the same cycle.
- bus_rdata_in  in  DATA_WIDTH  bus read data.

Behaviour:
- Reset (mem_arbiter_reset_in=0, asynchronous):
  - All outputs are 0, state = IDLE, wait counter = 0.
  - last_grant = LS, so the first tie goes to IF (boot fetch).
- States: IDLE, BUSY_IF, BUSY_LS. All outputs are registered.
- IDLE, on a posedge with a request pending:
  - Only IF pending: go to BUSY_IF.
  - Only LS pending: go to BUSY_LS.
  - Both pending: grant the requester opposite to last_grant (round-robin), then update last_grant.
- On a grant edge:
  - The gnt pulse is high for exactly the next cycle.
  - bus_req_out=1.
  - Address, we, wdata and be are captured into bus_* registers and held stable until the transaction ends.
  - IF transactions drive we=0, be=all ones, wdata=0.
  - Wait counter is cleared.
- Requests are sampled only in IDLE. A requester whose req is still high after its done pulse is making a new request.
- BUSY_x, edge with bus_ack_in=1:
  - Next cycle: bus_req_out=0 and done_x pulses for one cycle.
  - The matching rdata register captures bus_rdata_in. For LS, capture happens only on loads; stores leave ls_rdata_out unchanged.
  - err_out=0; state returns to IDLE.
- BUSY_x, edge without ack: wait counter increments.
  - If TIMEOUT>0 and the counter reaches TIMEOUT: abort. Next cycle has bus_req_out=0, done_x=1 and err_out=1; the rdata register is left unchanged; state returns to IDLE.
  - If ack and timeout fall on the same edge, ack wins.
- bus_ack_in is ignored in IDLE.
- Latency: request sampled at edge 0 → grant and bus_req_out at edge 0 → with ack at edge n, done is high in the cycle after edge n. The minimum is ack at edge 1, done one cycle later.
- A new grant can occur on the edge after done (IDLE lasts one cycle minimum).
- Reset asserted mid-transaction: bus_req_out drops immediately. No done or err pulse is issued, and the in-flight transaction is lost.
- The wait counter is wide enough to hold TIMEOUT without wrap.

Test Plan:
- Single fetch: if_req with addr 0x0000_0100, bus acks 1 cycle after bus_req with rdata 0x0000_0013 → bus_addr=0x100, be=0xF, we=0; if_gnt pulses once; if_done pulses once; if_rdata=0x13.
- Tie sequence: if_req and ls_req asserted together from reset, each held until its grant and reasserted after its done → grant order IF, LS, IF, LS; no cycle has both gnt pulses.
- Store then load: LS store to 0x200 with wdata 0xDEADBEEF and be=0x3, then a load with bus rdata 0x12345678 → the bus sees we=1, be=0x3 and the data; ls_rdata_out stays 0 after the store and is 0x12345678 after the load.
- Wait states: ack delayed 5 cycles → bus_addr, bus_we and bus_wdata stay constant for all 5 cycles; done arrives 1 cycle after ack; err_out=0.
- Timeout: TIMEOUT=4 with no ack → after 4 edges, done and err_out pulse together and if_rdata is unchanged. With ack arriving on the 4th edge, err_out=0.
- Reset mid-transaction: reset pulsed low during BUSY_LS → bus_req_out and the gnt/done outputs are 0 asynchronously; after release, a tie is granted to IF.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the single memory bus between instruction fetch
// and load/store, with a valid/ack handshake and a wait-state watchdog.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    mem_arbiter_clock_in,
  input  logic                    mem_arbiter_reset_in,
  input  logic                    if_req_in,
  input  logic [ADDR_WIDTH-1:0]   if_addr_in,
  output logic                    if_gnt_out,
  output logic                    if_done_out,
  output logic [DATA_WIDTH-1:0]   if_rdata_out,
  input  logic                    ls_req_in,
  input  logic                    ls_we_in,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_in,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] ls_be_in,
  output logic                    ls_gnt_out,
  output logic                    ls_done_out,
  output logic [DATA_WIDTH-1:0]   ls_rdata_out,
  output logic                    err_out,
  output logic                    bus_req_out,
  output logic                    bus_we_out,
  output logic [ADDR_WIDTH-1:0]   bus_addr_out,
  output logic [DATA_WIDTH-1:0]   bus_wdata_out,
  output logic [DATA_WIDTH/8-1:0] bus_be_out,
  input  logic                    bus_ack_in,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_in
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic                  last_ls_r, last_ls_s;
  logic [CNT_WIDTH-1:0]  wait_cnt_r, wait_cnt_s, wait_cnt_inc_s;
  logic                  grant_ls_s, busy_ls_s;
  logic                  if_gnt_r, if_gnt_s, ls_gnt_r, ls_gnt_s;
  logic                  if_done_r, if_done_s, ls_done_r, ls_done_s;
  logic                  err_r, err_s;
  logic                  bus_req_r, bus_req_s, bus_we_r, bus_we_s;
  logic [ADDR_WIDTH-1:0] bus_addr_r, bus_addr_s;
  logic [DATA_WIDTH-1:0] bus_wdata_r, bus_wdata_s;
  logic [BE_WIDTH-1:0]   bus_be_r, bus_be_s;
  logic [DATA_WIDTH-1:0] if_rdata_r, if_rdata_s, ls_rdata_r, ls_rdata_s;

  // Next-state and next-output logic for the arbitration/transaction FSM.
  always_comb begin
    state_s        = state_r;
    last_ls_s      = last_ls_r;
    wait_cnt_s     = wait_cnt_r;
    wait_cnt_inc_s = wait_cnt_r + CNT_ONE;
    // LS wins when it is alone, or on a tie when IF was served last.
    grant_ls_s     = ls_req_in & (~if_req_in | ~last_ls_r);
    busy_ls_s      = (state_r == ST_BUSY_LS);
    if_gnt_s       = 1'b0;
    ls_gnt_s       = 1'b0;
    if_done_s      = 1'b0;
    ls_done_s      = 1'b0;
    err_s          = 1'b0;
    bus_req_s      = bus_req_r;
    bus_we_s       = bus_we_r;
    bus_addr_s     = bus_addr_r;
    bus_wdata_s    = bus_wdata_r;
    bus_be_s       = bus_be_r;
    if_rdata_s     = if_rdata_r;
    ls_rdata_s     = ls_rdata_r;
    case (state_r)
      ST_IDLE: begin
        bus_req_s = 1'b0;
        if (if_req_in | ls_req_in) begin
          bus_req_s  = 1'b1;
          wait_cnt_s = {CNT_WIDTH{1'b0}};
          last_ls_s  = grant_ls_s;
          if (grant_ls_s) begin
            state_s     = ST_BUSY_LS;
            ls_gnt_s    = 1'b1;
            bus_we_s    = ls_we_in;
            bus_addr_s  = ls_addr_in;
            bus_wdata_s = ls_wdata_in;
            bus_be_s    = ls_be_in;
          end else begin
            state_s     = ST_BUSY_IF;
            if_gnt_s    = 1'b1;
            bus_we_s    = 1'b0;
            bus_addr_s  = if_addr_in;
            bus_wdata_s = {DATA_WIDTH{1'b0}};
            bus_be_s    = {BE_WIDTH{1'b1}};
          end
        end else begin
          wait_cnt_s = wait_cnt_r;
        end
      end
      ST_BUSY_IF, ST_BUSY_LS: begin
        if (bus_ack_in) begin
          state_s   = ST_IDLE;
          bus_req_s = 1'b0;
          if (busy_ls_s) begin
            ls_done_s = 1'b1;
            if (!bus_we_r) begin
              ls_rdata_s = bus_rdata_in;
            end else begin
              ls_rdata_s = ls_rdata_r;
            end
          end else begin
            if_done_s  = 1'b1;
            if_rdata_s = bus_rdata_in;
          end
        end else if (TIMEOUT_EN && (wait_cnt_inc_s == CNT_LIMIT)) begin
          // Watchdog abort: finish with an error, read data registers untouched.
          state_s    = ST_IDLE;
          bus_req_s  = 1'b0;
          err_s      = 1'b1;
          wait_cnt_s = wait_cnt_inc_s;
          if_done_s  = ~busy_ls_s;
          ls_done_s  = busy_ls_s;
        end else begin
          wait_cnt_s = wait_cnt_inc_s;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        bus_req_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge mem_arbiter_clock_in or negedge mem_arbiter_reset_in) begin
    if (!mem_arbiter_reset_in) begin
      state_r     <= ST_IDLE;
      last_ls_r   <= 1'b1;
      wait_cnt_r  <= {CNT_WIDTH{1'b0}};
      if_gnt_r    <= 1'b0;
      ls_gnt_r    <= 1'b0;
      if_done_r   <= 1'b0;
      ls_done_r   <= 1'b0;
      err_r       <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= {ADDR_WIDTH{1'b0}};
      bus_wdata_r <= {DATA_WIDTH{1'b0}};
      bus_be_r    <= {BE_WIDTH{1'b0}};
      if_rdata_r  <= {DATA_WIDTH{1'b0}};
      ls_rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      last_ls_r   <= last_ls_s;
      wait_cnt_r  <= wait_cnt_s;
      if_gnt_r    <= if_gnt_s;
      ls_gnt_r    <= ls_gnt_s;
      if_done_r   <= if_done_s;
      ls_done_r   <= ls_done_s;
      err_r       <= err_s;
      bus_req_r   <= bus_req_s;
      bus_we_r    <= bus_we_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
      bus_be_r    <= bus_be_s;
      if_rdata_r  <= if_rdata_s;
      ls_rdata_r  <= ls_rdata_s;
    end
  end

  assign if_gnt_out    = if_gnt_r;
  assign ls_gnt_out    = ls_gnt_r;
  assign if_done_out   = if_done_r;
  assign ls_done_out   = ls_done_r;
  assign err_out       = err_r;
  assign bus_req_out   = bus_req_r;
  assign bus_we_out    = bus_we_r;
  assign bus_addr_out  = bus_addr_r;
  assign bus_wdata_out = bus_wdata_r;
  assign bus_be_out    = bus_be_r;
  assign if_rdata_out  = if_rdata_r;
  assign ls_rdata_out  = ls_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and randomized transactions against a transaction-level
// model (round-robin winner, expected bus fields, read-data registers), plus a TIMEOUT=4 instance.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          if_req_in, if_gnt_out, if_done_out;
  logic [AW-1:0] if_addr_in;
  logic [DW-1:0] if_rdata_out;
  logic          ls_req_in, ls_we_in, ls_gnt_out, ls_done_out;
  logic [AW-1:0] ls_addr_in;
  logic [DW-1:0] ls_wdata_in, ls_rdata_out;
  logic [BW-1:0] ls_be_in;
  logic          err_out, bus_req_out, bus_we_out, bus_ack_in;
  logic [AW-1:0] bus_addr_out;
  logic [DW-1:0] bus_wdata_out, bus_rdata_in;
  logic [BW-1:0] bus_be_out;

  logic          t_if_req, t_if_gnt, t_if_done, t_ls_req, t_ls_we, t_ls_gnt, t_ls_done;
  logic [AW-1:0] t_if_addr, t_ls_addr, t_bus_addr;
  logic [DW-1:0] t_if_rdata, t_ls_rdata, t_ls_wdata, t_bus_wdata, t_rdata;
  logic [BW-1:0] t_ls_be, t_bus_be;
  logic          t_err, t_bus_req, t_bus_we, t_ack;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .mem_arbiter_clock_in(clk), .mem_arbiter_reset_in(rst_n),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_gnt_out(if_gnt_out),
    .if_done_out(if_done_out), .if_rdata_out(if_rdata_out),
    .ls_req_in(ls_req_in), .ls_we_in(ls_we_in), .ls_addr_in(ls_addr_in),
    .ls_wdata_in(ls_wdata_in), .ls_be_in(ls_be_in), .ls_gnt_out(ls_gnt_out),
    .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out), .err_out(err_out),
    .bus_req_out(bus_req_out), .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
    .bus_wdata_out(bus_wdata_out), .bus_be_out(bus_be_out),
    .bus_ack_in(bus_ack_in), .bus_rdata_in(bus_rdata_in)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut_t4 (
    .mem_arbiter_clock_in(clk), .mem_arbiter_reset_in(rst_n),
    .if_req_in(t_if_req), .if_addr_in(t_if_addr), .if_gnt_out(t_if_gnt),
    .if_done_out(t_if_done), .if_rdata_out(t_if_rdata),
    .ls_req_in(t_ls_req), .ls_we_in(t_ls_we), .ls_addr_in(t_ls_addr),
    .ls_wdata_in(t_ls_wdata), .ls_be_in(t_ls_be), .ls_gnt_out(t_ls_gnt),
    .ls_done_out(t_ls_done), .ls_rdata_out(t_ls_rdata), .err_out(t_err),
    .bus_req_out(t_bus_req), .bus_we_out(t_bus_we), .bus_addr_out(t_bus_addr),
    .bus_wdata_out(t_bus_wdata), .bus_be_out(t_bus_be),
    .bus_ack_in(t_ack), .bus_rdata_in(t_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model state: who was served last, and what each rdata register should hold.
  logic          m_last_ls;
  logic [DW-1:0] m_if_rdata, m_ls_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [68:0] bus_now();
    return {bus_we_out, bus_addr_out, bus_wdata_out, bus_be_out};
  endfunction

  task automatic model_reset();
    m_last_ls  = 1'b1;
    m_if_rdata = 32'd0;
    m_ls_rdata = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req_in = 1'b0;
    ls_req_in = 1'b0;
    bus_ack_in = 1'b0;
    #1;
    chk("reset_bus_req", {bus_req_out, if_gnt_out, ls_gnt_out, if_done_out, ls_done_out}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic new_req(input logic do_if, input logic do_ls);
    if (do_if) begin
      if_req_in  = 1'b1;
      if_addr_in = $urandom;
    end
    if (do_ls) begin
      ls_req_in   = 1'b1;
      ls_we_in    = 1'($urandom_range(0, 1));
      ls_addr_in  = $urandom;
      ls_wdata_in = $urandom;
      ls_be_in    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      if (if_gnt_out || ls_gnt_out) begin
        who = ls_gnt_out ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (who < 0) chk("gnt_timeout", 128'd0, 128'd1);
  endtask

  // One complete transaction: grant check, d wait states, ack with rd, done check.
  task automatic txn(input int d, input logic [DW-1:0] rd, input logic rereq);
    int who, exp_who;
    logic [68:0] exp_bus;
    logic is_store;
    exp_who = (if_req_in && ls_req_in) ? (m_last_ls ? 0 : 1) : (ls_req_in ? 1 : 0);
    exp_bus = (exp_who == 0) ? {1'b0, if_addr_in, 32'd0, 4'hF}
                             : {ls_we_in, ls_addr_in, ls_wdata_in, ls_be_in};
    is_store = (exp_who == 1) && ls_we_in;
    wait_gnt(who);
    if (who < 0) return;
    m_last_ls = (exp_who == 1);
    chk("gnt_pulse", {if_gnt_out, ls_gnt_out}, {exp_who == 0, exp_who == 1});
    chk("bus_start", {bus_req_out, bus_now()}, {1'b1, exp_bus});
    if (who == 0) if_req_in = 1'b0; else ls_req_in = 1'b0;
    for (int k = 0; k < d; k++) begin
      @(negedge clk);
      chk("wait_hold", {bus_req_out, if_gnt_out, ls_gnt_out, if_done_out, ls_done_out, bus_now()},
          {1'b1, 4'b0000, exp_bus});
    end
    bus_ack_in   = 1'b1;
    bus_rdata_in = rd;
    @(negedge clk);
    bus_ack_in   = 1'b0;
    bus_rdata_in = $urandom;
    if (exp_who == 0) m_if_rdata = rd;
    else if (!is_store) m_ls_rdata = rd;
    chk("done", {bus_req_out, if_gnt_out, ls_gnt_out, if_done_out, ls_done_out, err_out},
        {3'b000, exp_who == 0, exp_who == 1, 1'b0});
    chk("rdata", {if_rdata_out, ls_rdata_out}, {m_if_rdata, m_ls_rdata});
    if (rereq) begin
      if (who == 0) new_req(1'b1, 1'b0); else new_req(1'b0, 1'b1);
    end
    @(negedge clk);
    chk("done_single", {if_done_out, ls_done_out, err_out}, 3'b000);
  endtask

  task automatic t4_fetch_gnt();
    int got;
    got = 0;
    t_if_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_if_gnt) begin
        got = 1;
        break;
      end
    end
    chk("t4_gnt", 128'(got), 128'd1);
    t_if_req = 1'b0;
  endtask

  initial begin
    int who;
    logic [1:0] sel;
    if_req_in = 1'b0; if_addr_in = 32'd0; ls_req_in = 1'b0; ls_we_in = 1'b0;
    ls_addr_in = 32'd0; ls_wdata_in = 32'd0; ls_be_in = 4'd0;
    bus_ack_in = 1'b0; bus_rdata_in = 32'd0;
    t_if_req = 1'b0; t_if_addr = 32'h0000_0400; t_ls_req = 1'b0; t_ls_we = 1'b0;
    t_ls_addr = 32'd0; t_ls_wdata = 32'd0; t_ls_be = 4'd0; t_ack = 1'b0; t_rdata = 32'd0;
    model_reset();

    #12;
    chk("reset_ctrl", {if_gnt_out, if_done_out, ls_gnt_out, ls_done_out, err_out, bus_req_out,
        bus_we_out, bus_be_out, bus_addr_out, bus_wdata_out}, 128'd0);
    chk("reset_rdata", {if_rdata_out, ls_rdata_out, t_bus_req}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch, ack on the first edge after grant
    if_req_in = 1'b1;
    if_addr_in = 32'h0000_0100;
    txn(0, 32'h0000_0013, 1'b0);
    chk("fetch_rdata", if_rdata_out, 32'h0000_0013);

    // Ack while idle must be ignored
    bus_ack_in = 1'b1;
    bus_rdata_in = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    bus_ack_in = 1'b0;
    chk("idle_ack", {bus_req_out, if_done_out, ls_done_out, err_out, if_rdata_out, ls_rdata_out},
        {4'b0000, 32'h0000_0013, 32'd0});

    // Tie from reset with re-requests: IF, LS, IF, LS, IF, LS
    do_reset();
    new_req(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) txn(1, $urandom, (i < 4) ? 1'b1 : 1'b0);

    // Store leaves ls_rdata alone, load captures it
    do_reset();
    ls_req_in = 1'b1; ls_we_in = 1'b1; ls_addr_in = 32'h0000_0200;
    ls_wdata_in = 32'hDEAD_BEEF; ls_be_in = 4'h3;
    txn(2, 32'hCAFE_F00D, 1'b0);
    chk("store_keeps_rdata", ls_rdata_out, 32'd0);
    ls_req_in = 1'b1; ls_we_in = 1'b0; ls_addr_in = 32'h0000_0204;
    txn(0, 32'h1234_5678, 1'b0);
    chk("load_rdata", ls_rdata_out, 32'h1234_5678);

    // Five wait states
    if_req_in = 1'b1;
    if_addr_in = 32'h0000_0300;
    txn(5, 32'h0BEE_F00D, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if (!if_req_in && !ls_req_in) begin
        sel = 2'($urandom_range(1, 3));
        new_req(sel[0], sel[1]);
      end
      txn($urandom_range(0, 6), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2; i++) begin
      if (if_req_in || ls_req_in) txn($urandom_range(0, 3), $urandom, 1'b0);
    end

    // Reset in the middle of a load
    new_req(1'b0, 1'b1);
    wait_gnt(who);
    ls_req_in = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outs", {bus_req_out, if_gnt_out, ls_gnt_out, if_done_out, ls_done_out, err_out},
        6'd0);
    new_req(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    txn(0, $urandom, 1'b0);
    txn(0, $urandom, 1'b0);

    // TIMEOUT=4 instance: good fetch, then a timeout, then ack on the 4th edge
    t4_fetch_gnt();
    t_ack = 1'b1;
    t_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    t_ack = 1'b0;
    chk("t4_fetch", {t_if_done, t_err, t_if_rdata}, {2'b10, 32'hA5A5_5A5A});
    @(negedge clk);
    t4_fetch_gnt();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_waiting", {t_if_done, t_err, t_bus_req}, 3'b001);
    end
    @(negedge clk);
    chk("t4_timeout", {t_if_done, t_err, t_bus_req, t_if_rdata}, {3'b110, 32'hA5A5_5A5A});
    @(negedge clk);
    chk("t4_err_pulse", {t_if_done, t_err}, 2'b00);
    t4_fetch_gnt();
    for (int k = 0; k < 3; k++) @(negedge clk);
    t_ack = 1'b1;
    t_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    t_ack = 1'b0;
    chk("t4_ack_wins", {t_if_done, t_err, t_if_rdata}, {2'b10, 32'h0BAD_F00D});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
